// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver.
//   rx_state_t  - receiver FSM states (PARITY present only when the parity
//                 option is built in)
//   *_LEVEL     - line levels for idle, start bit and stop bit
//   even_parity - even-parity bit over a vector of up to 16 bits
// Build option: SERIAL_FRAME_RX_PARITY_EN adds the PARITY state.
package serial_frame_pkg;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int PARITY_MAX_W = 16;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;
`endif

    // The bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to the idle line level so that reset never looks like
// a start bit.
//   clk   - system clock
//   reset - synchronous, active-high reset
//   d     - raw serial line
//   q     - synchronized serial line
module rx_sync
    import serial_frame_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit (0), DATA_BITS data bits LSB first,
// [even parity bit], stop bit (1); line idles high. The line is sampled at
// mid-bit by a clock-count timer and each frame is presented as a parallel
// word on a valid/ready handshake. Receiving never stalls.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   rx          - serial line, idle high
//   out_data    - received word, stable while out_valid=1
//   out_valid   - word available
//   out_ready   - consumer accepts when out_valid & out_ready
//   frame_err   - one-cycle pulse: stop bit sampled low
//   overrun     - one-cycle pulse: unaccepted word overwritten
//   busy        - receiver not idle
//   parity_err  - (parity build only) one-cycle pulse: parity mismatch
// Build option: define SERIAL_FRAME_RX_PARITY_EN to add the parity bit.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef SERIAL_FRAME_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Half a bit lands the first sample in the middle of the start bit;
    // every later sample is one full bit further on.
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                 par_bit;
`endif

    rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // The assembly register carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Consumer handshake; a word delivered in this same cycle
            // below takes precedence over the clear.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state <= START;
                        timer <= HALF_RELOAD;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (rx_s == START_LEVEL) begin
                        state   <= DATA;
                        timer   <= BIT_RELOAD;
                        bit_idx <= '0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                DATA: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        shreg[bit_idx] <= rx_s;
                        timer          <= BIT_RELOAD;
                        if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end

`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        par_bit <= rx_s;
                        timer   <= BIT_RELOAD;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        // Back to IDLE at mid-stop so a start bit right
                        // after the stop bit is still caught.
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        if (par_bit != even_parity(PARITY_MAX_W'(shreg))) begin
                            parity_err <= 1'b1;
                        end else
`endif
                        if (rx_s == STOP_LEVEL) begin
                            out_data  <= shreg;
                            out_valid <= 1'b1;
                            overrun   <= out_valid & ~out_ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed scenarios plus randomized frames.
// Every frame issued pushes its expected outcome (word, framing error,
// parity error, overrun) into a queue; a monitor pops and compares each
// time the DUT reports an event or completes a handshake.
module tb_serial_frame_rx;

    localparam int DB  = 8;
    localparam int CPB = 4;
    // Edge at which out_valid rises, counting the edge that first samples
    // the start bit as edge 1.
    localparam int LAT_EDGES = 3 + CPB / 2 + (DB + 1) * CPB;

    localparam int K_WORD = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;
    localparam int K_PERR = 3;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          out_ready;
    logic [DB-1:0] out_data;
    logic          out_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic          parity_err;
`endif

    ev_t  expq[$];
    int   vectors        = 0;
    int   miscompares    = 0;
    int   cyc            = 0;
    int   start_edge     = 0;
    int   valid_rise_cyc = 0;
    logic prev_valid     = 1'b0;

    serial_frame_rx #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        expq.push_back(e);
    endtask

    task automatic observe(input int kind, input int data);
        ev_t e;
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected event: got kind=%0d data=0x%0h, expected none", kind, data);
        end else begin
            e = expq.pop_front();
            check("event kind", kind, e.kind);
            if (e.kind == K_WORD && kind == K_WORD) check("word", data, e.data);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = out_valid;
            if (frame_err) observe(K_FERR, 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
            if (parity_err) observe(K_PERR, 0);
`endif
            if (overrun) observe(K_OVR, 0);
            if (out_valid && out_ready) observe(K_WORD, int'(out_data));
        end
    end

    // Stimulus tasks are entered 1 ns after a rising edge.
    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] w, input logic stop_b, input logic par_good);
        start_edge = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(w[i]);
        if (PAR_ON) send_bit(par_good ? ^w : ~^w);
        send_bit(stop_b);
    endtask

    // Reference outcome of one frame: parity error beats framing error,
    // otherwise the word is delivered.
    task automatic issue(input logic [DB-1:0] w, input logic stop_b, input logic par_good);
        if (PAR_ON && !par_good) expect_ev(K_PERR, 0);
        else if (stop_b !== 1'b1) expect_ev(K_FERR, 0);
        else expect_ev(K_WORD, int'(w));
        send_frame(w, stop_b, par_good);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        ev_t           e;
        logic          saw;
        logic [DB-1:0] w;
        logic          stop_b;
        logic          par_good;

        reset     = 1'b1;
        rx        = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset overrun", 32'(overrun), 0);
        check("reset busy", 32'(busy), 0);
        reset = 1'b0;
        idle(4);

        // Single frame, consumer always ready.
        issue(8'hA5, 1'b1, 1'b1);
        idle(2);
        check("latency 0xA5", 32'(valid_rise_cyc - start_edge + 1), LAT_EDGES);

        // One-cycle low glitch: busy pulses, nothing is reported.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx  = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        check("glitch busy pulse", 32'(saw), 1);
        @(posedge clk);
        #1;
        check("glitch back to idle", 32'(busy), 0);
        check("glitch no out_valid", 32'(out_valid), 0);

        // Stop bit low, then a good frame.
        issue(8'h3C, 1'b0, 1'b1);
        idle(2 * CPB);
        check("frame error no out_valid", 32'(out_valid), 0);
        issue(8'h5A, 1'b1, 1'b1);
        idle(4);

        // Overrun: two back-to-back frames with the consumer stalled.
        out_ready = 1'b0;
        expect_ev(K_OVR, 0);
        expect_ev(K_WORD, 'h22);
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(4);
        check("overrun holds new word", 32'(out_data), 'h22);
        check("overrun out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid clears after accept", 32'(out_valid), 0);
        idle(4);

        // Reset during data bit 4 of 0xFF, with an unaccepted word pending.
        out_ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b1);
        idle(2);
        check("pending word present", 32'(out_valid), 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid-frame reset out_valid", 32'(out_valid), 0);
        check("mid-frame reset out_data", 32'(out_data), 0);
        check("mid-frame reset busy", 32'(busy), 0);
        check("mid-frame reset frame_err", 32'(frame_err), 0);
        out_ready = 1'b1;
        idle(2 * CPB);
        issue(8'h81, 1'b1, 1'b1);
        idle(4);

        if (PAR_ON) begin
            issue(8'h07, 1'b1, 1'b1);
            idle(4);
            issue(8'h07, 1'b1, 1'b0);
            idle(4);
            issue(8'h07, 1'b0, 1'b0);
            idle(2 * CPB);
        end

        // Randomized frames with occasional framing/parity errors and
        // random inter-frame gaps (including none).
        for (int n = 0; n < 40; n++) begin
            w        = DB'($urandom_range(0, (1 << DB) - 1));
            stop_b   = ($urandom_range(0, 5) != 0);
            par_good = PAR_ON ? ($urandom_range(0, 5) != 0) : 1'b1;
            issue(w, stop_b, par_good);
            if (!stop_b) idle(2 * CPB + int'($urandom_range(0, 5)));
            else idle(int'($urandom_range(0, 6)));
        end
        idle(4);

        for (int i = 0; i < 2000 && expq.size() > 0; i++) @(posedge clk);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing event: got nothing, expected kind=%0d data=0x%0h", e.kind, e.data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Synchronous serial frame receiver, the consuming end of the team's registered single-bit serial line.
- Line format: one start bit (0), DATA_BITS data bits (LSB first), then one stop bit (1). The line idles at 1.
- Samples the line at mid-bit using a clock-count bit timer.
- Assembles each frame into a parallel word and presents it on a valid/ready output handshake.
- Flags framing and overrun errors. Sits between the serial line and the parallel consumer logic.

Parameters:
DATA_BITS, 8, number of data bits per frame (1..16)
CLKS_PER_BIT, 4, clk cycles per serial bit; must be even and >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  serial line, idle high
out_data  output  DATA_BITS  received word; valid while out_valid=1
out_valid  output  1  received word available
out_ready  input  1  consumer accepts word when out_valid & out_ready
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: new word completed while previous word still unaccepted
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, bit counter=0, timer=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is built in).
- IDLE: if rx_s==0, go to START and load timer=CLKS_PER_BIT/2-1.
- START: decrement timer. At 0, sample rx_s:
  - 0: go to DATA with timer=CLKS_PER_BIT-1 and bit index=0.
  - 1: glitch; return to IDLE. No error is reported.
- DATA: when timer==0, shift rx_s into bit[index] (LSB first) and reload timer. After bit DATA_BITS-1 is captured, go to STOP.
- STOP: when timer==0, sample rx_s:
  - 1: load out_data with the shift register, set out_valid, go to IDLE.
  - 0: pulse frame_err for one cycle, leave out_data/out_valid unchanged, go to IDLE.
  - No break detection: after a frame_err, a still-low line immediately starts a new frame.
- Latency: out_valid rises 3 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the first posedge at which rx is sampled 0. With the defaults this is 41 cycles.
- Handshake:
  - out_valid stays high and out_data stays stable until the cycle in which out_valid & out_ready; out_valid clears on the next edge.
  - out_ready has no effect while out_valid=0.
  - Receiving never stalls; the line is not flow-controlled.
- Overrun: a frame completes in the STOP state while out_valid=1 and out_ready=0.
  - out_data is overwritten with the new word, out_valid stays 1, and overrun pulses for one cycle.
  - If out_ready=1 in that same cycle, the old word counts as consumed, the new word is loaded with out_valid=1, and overrun does not pulse.
- Back-to-back frames: the FSM returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- Reset mid-frame: the frame is discarded, all outputs return to their reset values, and the pending word is lost.

Optional Feature:
- Macro SERIAL_FRAME_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit.
  - Mismatch: the word is not delivered, and a one-cycle parity_err output pulse is emitted in the STOP-sample cycle.
  - parity_err takes priority over frame_err if both errors occur; only one pulse is emitted.
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state and no parity_err port; frame length is DATA_BITS+2 bits.

Decomposition:
- Package serial_frame_pkg holds:
  - the FSM state enum (rx_state_t);
  - the constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1;
  - the function for even parity over a vector.
- Sub-module rx_sync: the 2-flop synchronizer with reset value 1, in its own file.

Test Plan:
- Defaults; send 0xA5 framed (0, bits 1,0,1,0,0,1,0,1, then 1) with out_ready=1 -> out_valid at cycle 41, out_data=0xA5, no error pulses.
- rx low for 1 cycle, then high -> busy pulses, returns to IDLE, out_valid stays 0, no frame_err.
- Send 0x3C with the stop bit forced 0 -> frame_err=1 for one cycle, out_valid stays 0; a following valid 0x5A is received correctly.
- out_ready=0; send 0x11 then 0x22 back-to-back -> after the 2nd frame out_data=0x22, out_valid=1, overrun pulses once; raise out_ready -> out_valid clears on the next edge.
- Assert reset during data bit 4 of 0xFF -> all outputs 0 next cycle; the next frame 0x81 is received correctly.
- With SERIAL_FRAME_RX_PARITY_EN: send 0x07 with parity bit 1 -> delivered; send it with parity bit 0 -> parity_err pulse, no out_valid.
